ins_fetch_ctrl: RTL and testbench
=================================

INS_FETCH_CTRL -- requirements
Module: ins_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter MAX_WAIT, 16: cycles in WAIT without a hit before oerr sets.
REQ-003 Port clk  input  1: single clock; all state updates on posedge.
REQ-004 Port rstn  input  1: reset, asynchronous, active-low.
REQ-005 Port icache_hit  input  1: cache hit flag, registered by the instruction cache, valid for the address it sampled at the previous posedge.
REQ-006 Port icache_ins  input  32: instruction word from the cache, qualified by icache_hit.
REQ-007 Port istall  input  1: downstream decode stall; 1 = IF/ID register holds.
REQ-008 Port ibranch_taken  input  1: redirect request, one-cycle pulse.
REQ-009 Port ibranch_target  input  32: redirect address, sampled when ibranch_taken=1.
REQ-010 Port oaddr  output  32: fetch address to the instruction cache, equal to the PC register.
REQ-011 Port oins  output  32: IF/ID instruction register.
REQ-012 Port opc4  output  32: IF/ID register holding fetched PC + 4.
REQ-013 Port ovalid  output  1: oins/opc4 hold a valid instruction.
REQ-014 Port oerr  output  1: sticky fetch-timeout flag.

Function
REQ-015 FSM states: REQ, WAIT, HOLD; all registers update on posedge clk only.
REQ-016 REQ: oaddr=pc; next state WAIT; wait counter cleared to 0.
REQ-017 WAIT, icache_hit=1, istall=0: oins<=icache_ins, opc4<=pc+4, ovalid<=1, pc<=pc+4, next REQ.
REQ-018 WAIT, icache_hit=1, istall=1: pend<=icache_ins, pc unchanged, next HOLD.
REQ-019 WAIT, icache_hit=0: wait counter increments; when it reaches MAX_WAIT-1, oerr<=1; state stays WAIT; counter saturates.
REQ-020 HOLD, istall=0: oins<=pend, opc4<=pc+4, ovalid<=1, pc<=pc+4, next REQ; istall=1: stay HOLD.
REQ-021 IF/ID register (oins, opc4, ovalid) holds unchanged in any cycle with istall=1.
REQ-022 istall=0 and no instruction delivered this cycle: ovalid<=0 (bubble); oins/opc4 hold old values.
REQ-023 PC arithmetic modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
REQ-024 ibranch_taken=1 overrides stall, hit, and state: pc<={ibranch_target[31:2],2'b00}, ovalid<=0, pend discarded, wait counter<=0, next REQ.
REQ-025 Branch coincident with a WAIT hit: the hit instruction is discarded; the branch wins.
REQ-026 Hit latency: 2 cycles from entering REQ to ovalid=1; peak throughput 1 instruction per 2 cycles.
REQ-027 oaddr stays stable across WAIT and HOLD, so the cache refills the same line on a miss.
REQ-028 oerr clears only on reset; it does not stop fetching.

Reset
REQ-029 rstn=0 forces, asynchronously: pc=RESET_PC, state=REQ, oins=0, opc4=0, ovalid=0, oerr=0, pend=0, wait counter=0.
REQ-030 Reset mid-WAIT or mid-HOLD discards the in-flight fetch.
REQ-031 First REQ occurs on the first posedge after rstn deasserts.

Verification
REQ-032 Reset, cache model returns a hit 1 cycle after each address -> oaddr 0,4,8 on every other cycle; oins matches each word; opc4=4,8,12; ovalid pulses 1 every 2nd cycle.
REQ-033 Miss at pc=0x40: hit arrives 4 cycles late -> oaddr held at 0x40 throughout; ovalid=0 until the hit; then oins=word(0x40), opc4=0x44; oerr=0.
REQ-034 Hit arrives with istall=1 for 3 cycles -> state HOLD; IF/ID unchanged; pc=0x10 held; first cycle after istall=0: oins=pend, opc4=0x14, ovalid=1.
REQ-035 ibranch_taken with target 0x1003 in the same cycle as a WAIT hit -> hit discarded; ovalid=0; next oaddr=0x1000.
REQ-036 Cache never hits, MAX_WAIT=16 -> oerr=1 exactly 16 cycles after entering WAIT and stays 1; rstn pulse clears it.
REQ-037 pc=0xFFFF_FFFC, hit -> opc4=0x0000_0000; next oaddr=0x0000_0000.

Source files
------------

// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch controller: drives the I-cache fetch address, waits for a
// registered hit, and loads the IF/ID register with stall, branch and timeout handling.
module ins_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        icache_hit,
    input  logic [31:0] icache_ins,
    input  logic        istall,
    input  logic        ibranch_taken,
    input  logic [31:0] ibranch_target,
    output logic [31:0] oaddr,
    output logic [31:0] oins,
    output logic [31:0] opc4,
    output logic        ovalid,
    output logic        oerr
);

    localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ins_q, ins_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            ins_q   <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        err_d   = err_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;

        // An unstalled cycle without a delivery leaves a bubble in IF/ID
        if (!istall) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (icache_hit) begin
                    if (!istall) begin
                        ins_d   = icache_ins;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = ST_REQ;
                    end else begin
                        pend_d  = icache_ins;
                        state_d = ST_HOLD;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!istall) begin
                    ins_d   = pend_q;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // Redirect wins over everything, including a hit landing this cycle
        if (ibranch_taken) begin
            pc_d    = {ibranch_target[31:2], 2'b00};
            ins_d   = ins_q;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
            pend_d  = 32'd0;
            cnt_d   = '0;
            state_d = ST_REQ;
        end
    end

    assign oaddr  = pc_q;
    assign oins   = ins_q;
    assign opc4   = pc4_q;
    assign ovalid = valid_q;
    assign oerr   = err_q;

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: registered cache model with per-address miss latency,
// scoreboard of expected (instruction, pc+4) pairs popped on each delivery.
module tb_ins_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        icache_hit = 1'b0;
    logic [31:0] icache_ins = 32'd0;
    logic        istall;
    logic        ibranch_taken;
    logic [31:0] ibranch_target;
    logic [31:0] oaddr;
    logic [31:0] oins;
    logic [31:0] opc4;
    logic        ovalid;
    logic        oerr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb_q[$];

    // cache model controls
    logic        c_en      = 1'b1;
    logic [31:0] miss_addr = 32'hFFFF_0000;
    int          miss_lat  = 0;
    int          c_cnt     = 0;
    logic [31:0] c_prev    = 32'hFFFF_FFFF;
    logic        last_stall = 1'b0;

    ins_fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(16)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .icache_hit    (icache_hit),
        .icache_ins    (icache_ins),
        .istall        (istall),
        .ibranch_taken (ibranch_taken),
        .ibranch_target(ibranch_target),
        .oaddr         (oaddr),
        .oins          (oins),
        .opc4          (opc4),
        .ovalid        (ovalid),
        .oerr          (oerr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Registered cache: hit reflects the address sampled at the previous edge
    always @(posedge clk) begin : cache_model
        int n;
        n = (oaddr == c_prev) ? c_cnt + 1 : 0;
        c_cnt      <= n;
        c_prev     <= oaddr;
        icache_hit <= c_en && ((oaddr != miss_addr) || (n >= miss_lat));
        icache_ins <= word(oaddr);
        last_stall <= istall;
    end

    // A fresh delivery is ovalid=1 after an edge that was not stalled
    always @(negedge clk) begin
        if (rstn && ovalid && !last_stall) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'(ovalid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_oins", oins, e.ins);
                check_eq("sb_opc4", opc4, e.pc4);
            end
        end
    end

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.ins = word(a);
        e.pc4 = a + 32'd4;
        sb_q.push_back(e);
    endtask

    task automatic go(input logic [31:0] tgt);
        ibranch_taken  = 1'b1;
        ibranch_target = tgt;
        @(negedge clk);
        ibranch_taken  = 1'b0;
        check_eq("branch_oaddr", oaddr, {tgt[31:2], 2'b00});
    endtask

    logic [31:0] exp_addr[6];
    logic        exp_vld[6];

    initial begin
        rstn           = 1'b0;
        istall         = 1'b0;
        ibranch_taken  = 1'b0;
        ibranch_target = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_oaddr", oaddr, 32'd0);
        check_eq("rst_oins", oins, 32'd0);
        check_eq("rst_opc4", opc4, 32'd0);
        check_eq("rst_ovalid", 32'(ovalid), 32'd0);
        check_eq("rst_oerr", 32'(oerr), 32'd0);

        // Back-to-back hits from reset: 0, 4, 8
        exp_addr = '{32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12};
        exp_vld  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        push_exp(32'd0);
        push_exp(32'd4);
        push_exp(32'd8);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("seq_oaddr", oaddr, exp_addr[k]);
            check_eq("seq_ovalid", 32'(ovalid), 32'(exp_vld[k]));
        end
        c_en = 1'b0;

        // Miss at 0x40, hit four cycles late
        miss_addr = 32'h40;
        miss_lat  = 4;
        c_en      = 1'b1;
        push_exp(32'h40);
        go(32'h40);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("miss_oaddr", oaddr, 32'h40);
            check_eq("miss_ovalid", 32'(ovalid), 32'd0);
        end
        @(negedge clk);
        c_en = 1'b0;
        check_eq("miss_ovalid_hit", 32'(ovalid), 32'd1);
        check_eq("miss_oaddr_next", oaddr, 32'h44);
        check_eq("miss_oerr", 32'(oerr), 32'd0);

        // Stall for three cycles around the hit at 0x10
        c_en = 1'b1;
        push_exp(32'h0C);
        push_exp(32'h10);
        go(32'h0C);
        @(negedge clk);
        @(negedge clk);
        istall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_oaddr", oaddr, 32'h10);
            check_eq("stall_ovalid", 32'(ovalid), 32'd1);
            check_eq("stall_oins", oins, word(32'h0C));
            check_eq("stall_opc4", opc4, 32'h10);
        end
        istall = 1'b0;
        @(negedge clk);
        c_en = 1'b0;
        check_eq("hold_oins", oins, word(32'h10));
        check_eq("hold_opc4", opc4, 32'h14);
        check_eq("hold_ovalid", 32'(ovalid), 32'd1);
        check_eq("hold_oaddr", oaddr, 32'h14);

        // Branch coincident with a WAIT hit
        c_en = 1'b1;
        push_exp(32'h1000);
        go(32'h20);
        @(negedge clk);
        ibranch_taken  = 1'b1;
        ibranch_target = 32'h1003;
        @(negedge clk);
        ibranch_taken  = 1'b0;
        check_eq("br_ovalid", 32'(ovalid), 32'd0);
        check_eq("br_oaddr", oaddr, 32'h1000);
        @(negedge clk);
        @(negedge clk);
        c_en = 1'b0;
        check_eq("br_deliver_ovalid", 32'(ovalid), 32'd1);
        check_eq("br_deliver_oaddr", oaddr, 32'h1004);

        // PC wrap at the top of the address space
        c_en = 1'b1;
        push_exp(32'hFFFF_FFFC);
        go(32'hFFFF_FFFC);
        @(negedge clk);
        @(negedge clk);
        c_en = 1'b0;
        check_eq("wrap_opc4", opc4, 32'd0);
        check_eq("wrap_oaddr", oaddr, 32'd0);
        check_eq("wrap_oerr", 32'(oerr), 32'd0);

        // Cache never hits: timeout 16 cycles after entering WAIT, sticky
        go(32'h200);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check_eq("tmo_oerr", 32'(oerr), (k >= 17) ? 32'd1 : 32'd0);
        end
        check_eq("tmo_oaddr", oaddr, 32'h200);

        // Asynchronous reset clears the sticky flag and discards the fetch
        rstn = 1'b0;
        #1;
        check_eq("rst2_oerr", 32'(oerr), 32'd0);
        check_eq("rst2_oaddr", oaddr, 32'd0);
        check_eq("rst2_ovalid", 32'(ovalid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_oaddr", oaddr, 32'd0);
        check_eq("post_rst_oerr", 32'(oerr), 32'd0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
